// File: rtl/sipo_feeder_if.sv
// Word-in / serial-out bundle between an upstream word source, the feeder and
// a downstream shift register.
interface sipo_feeder_if #(
  parameter int COLS = 16
);
  logic            in_valid;
  logic [COLS-1:0] in_data;
  logic            in_ready;
  logic            serial_out;
  logic            shift_out;
  logic            load_out;
  logic            busy;
  logic            done;

  // The feeder itself.
  modport slave (
    input  in_valid, in_data,
    output in_ready, serial_out, shift_out, load_out, busy, done
  );

  // The word source and downstream observer.
  modport master (
    output in_valid, in_data,
    input  in_ready, serial_out, shift_out, load_out, busy, done
  );
endinterface

// File: rtl/sipo_feeder.sv
// Serializes COLS-bit words MSB first into a downstream shift register, then
// issues a one-cycle parallel-load strobe. A new word is taken during IDLE or LOAD.
module sipo_feeder #(
  parameter int COLS = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr,
  sipo_feeder_if.slave bus
);

  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] CNT_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] held_q, held_d;
  logic [CW-1:0]   bit_idx;
  logic            ready;
  logic            xfer;

  assign ready   = (state_q != ST_SHIFT);
  assign xfer    = bus.in_valid && ready && !clr;
  assign bit_idx = CNT_LAST - cnt_q;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (xfer) begin
            held_d  = bus.in_data;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: the holding register is a plain register, not a memory array, so it
  // is cheap to reset and its reset value keeps serial_out defined.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  // Outputs decode registered state only; in_data never reaches them directly.
  assign bus.in_ready   = ready;
  assign bus.shift_out  = (state_q == ST_SHIFT);
  assign bus.serial_out = (state_q == ST_SHIFT) && held_q[bit_idx];
  assign bus.load_out   = (state_q == ST_LOAD);
  assign bus.done       = (state_q == ST_LOAD);
  assign bus.busy       = (state_q == ST_SHIFT) || (state_q == ST_LOAD);

endmodule

// File: tb/tb_sipo_feeder.sv
// Self-checking bench for sipo_feeder: a schedule-based reference model for
// COLS=16 plus a vector table for a COLS=2 build.
module tb_sipo_feeder;

  localparam int COLS = 16;

  logic clk = 1'b0;
  logic arst_n;
  logic clr;
  logic clr2;

  always #5 clk = ~clk;

  sipo_feeder_if #(.COLS(COLS)) bus ();
  sipo_feeder_if #(.COLS(2))    bus2 ();

  sipo_feeder #(.COLS(COLS)) dut  (.clk(clk), .arst_n(arst_n), .clr(clr),  .bus(bus));
  sipo_feeder #(.COLS(2))    dut2 (.clk(clk), .arst_n(arst_n), .clr(clr2), .bus(bus2));

  typedef struct packed {
    logic ready;
    logic shift;
    logic load;
    logic serial;
    logic busy;
    logic done;
  } outs_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic outs_t mk(input logic r, input logic s, input logic l,
                               input logic se, input logic b, input logic d);
    outs_t o;
    o = '{ready: r, shift: s, load: l, serial: se, busy: b, done: d};
    return o;
  endfunction

  // Reference model: each accepted word expands into a schedule of
  // COLS shift cycles followed by one load cycle.
  outs_t           idle_o;
  outs_t           cur;
  outs_t           pend[$];
  logic [COLS-1:0] words[$];
  logic [COLS-1:0] sr;
  logic [COLS-1:0] stream;
  int              shifts;
  int              cyc;
  int              xfer_cyc;
  logic            last_xfer;
  int              loads[$];

  function automatic outs_t dut_outs();
    return mk(bus.in_ready, bus.shift_out, bus.load_out, bus.serial_out, bus.busy, bus.done);
  endfunction

  task automatic model_reset();
    pend.delete();
    words.delete();
    cur = idle_o;
  endtask

  // Called at a negedge: compare, drive inputs, advance one clock, return at next negedge.
  task automatic step(input logic v, input logic [COLS-1:0] d, input logic c);
    outs_t got;
    logic  xfer;
    got = dut_outs();
    check("outs", 32'(got), 32'(cur));
    if (got.load) loads.push_back(cyc);
    if (got.shift) begin
      stream = {stream[COLS-2:0], got.serial};
      shifts++;
    end
    if (cur.load && words.size() > 0) check("load_word", 32'(sr), 32'(words.pop_front()));
    xfer = v && cur.ready && !c;
    last_xfer = xfer;
    if (xfer) xfer_cyc = cyc;
    bus.in_valid = v;
    bus.in_data  = v ? d : 'x;
    clr          = c;
    @(posedge clk);
    if (got.shift) sr = {sr[COLS-2:0], got.serial};
    if (c) begin
      pend.delete();
      words.delete();
    end else if (xfer) begin
      words.push_back(d);
      for (int k = 1; k <= COLS; k++) pend.push_back(mk(1'b0, 1'b1, 1'b0, d[COLS-k], 1'b1, 1'b0));
      pend.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    end
    cur = (pend.size() > 0) ? pend.pop_front() : idle_o;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  // Load strobe and shift enable must never overlap, on either build.
  always @(negedge clk) begin
    check("no_overlap16", 32'(bus.shift_out & bus.load_out), 32'd0);
    check("no_overlap2", 32'(bus2.shift_out & bus2.load_out), 32'd0);
  end

  typedef struct {
    logic [COLS-1:0] word;
    logic [COLS-1:0] exp_stream;
  } word_vec_t;

  typedef struct {
    logic       v;
    logic [1:0] d;
    outs_t      exp;
  } vec2_t;

  initial begin
    word_vec_t       wv[6];
    vec2_t           v2[8];
    logic [COLS-1:0] b2b[3];
    int              idx;
    int              t0;
    int              nloads;
    outs_t           got;

    wv[0] = '{16'hA5C3, 16'b1010_0101_1100_0011};
    wv[1] = '{16'h0001, 16'b0000_0000_0000_0001};
    wv[2] = '{16'h8000, 16'b1000_0000_0000_0000};
    wv[3] = '{16'hFFFF, 16'b1111_1111_1111_1111};
    wv[4] = '{16'h0000, 16'b0000_0000_0000_0000};
    wv[5] = '{16'h1234, 16'b0001_0010_0011_0100};

    // COLS=2: 2'b10 then 2'b01 back-to-back, with in_data changing mid-frame.
    v2[0] = '{1'b1, 2'b10, mk(1, 0, 0, 0, 0, 0)};
    v2[1] = '{1'b1, 2'b11, mk(0, 1, 0, 1, 1, 0)};
    v2[2] = '{1'b1, 2'b01, mk(0, 1, 0, 0, 1, 0)};
    v2[3] = '{1'b1, 2'b01, mk(1, 0, 1, 0, 1, 1)};
    v2[4] = '{1'b0, 2'b00, mk(0, 1, 0, 0, 1, 0)};
    v2[5] = '{1'b0, 2'b00, mk(0, 1, 0, 1, 1, 0)};
    v2[6] = '{1'b0, 2'b00, mk(1, 0, 1, 0, 1, 1)};
    v2[7] = '{1'b0, 2'b00, mk(1, 0, 0, 0, 0, 0)};

    b2b[0] = 16'h0001;
    b2b[1] = 16'h8000;
    b2b[2] = 16'hFFFF;

    idle_o = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sr = '0; stream = '0; shifts = 0; cyc = 0; xfer_cyc = 0; last_xfer = 1'b0;
    model_reset();

    arst_n = 1'b0;
    clr = 1'b0; clr2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 'x;
    bus2.in_valid = 1'b0; bus2.in_data = 'x;

    // Reset state: all registered outputs low.
    repeat (3) @(negedge clk);
    got = dut_outs();
    check("reset_outs", 32'({got.shift, got.load, got.serial, got.busy, got.done}), 32'd0);
    arst_n = 1'b1;

    // Single frames; the first transfer lands on the first edge after release.
    foreach (wv[i]) begin
      stream = '0;
      shifts = 0;
      step(1'b1, wv[i].word, 1'b0);
      idle_steps(COLS + 2);
      check("stream", 32'(stream), 32'(wv[i].exp_stream));
      check("shift_count", 32'(shifts), 32'(COLS));
    end

    // Back-to-back frames with in_valid held high.
    loads.delete();
    idx = 0;
    t0 = 0;
    for (int n = 0; n < 3 * (COLS + 1) + 3; n++) begin
      step(idx < 3, (idx < 3) ? b2b[idx] : '0, 1'b0);
      if (last_xfer) begin
        if (idx == 0) t0 = xfer_cyc;
        idx++;
      end
    end
    check("b2b_loads", 32'(loads.size()), 32'd3);
    if (loads.size() == 3) begin
      check("b2b_latency", 32'(loads[0] - t0), 32'(COLS + 1));
      check("b2b_period1", 32'(loads[1] - loads[0]), 32'(COLS + 1));
      check("b2b_period2", 32'(loads[2] - loads[1]), 32'(COLS + 1));
    end

    // Synchronous abort at shift cycle 7: no load for the aborted frame.
    nloads = loads.size();
    step(1'b1, 16'hBEEF, 1'b0);
    idle_steps(6);
    step(1'b0, '0, 1'b1);
    idle_steps(COLS + 2);
    check("clr_no_load", 32'(loads.size()), 32'(nloads));
    step(1'b1, 16'h1234, 1'b0);
    idle_steps(COLS + 2);
    check("clr_next_load", 32'(loads.size()), 32'(nloads + 1));

    // Asynchronous reset at shift cycle 10, mid-cycle.
    nloads = loads.size();
    step(1'b1, 16'hC0DE, 1'b0);
    idle_steps(9);
    #2 arst_n = 1'b0;
    #1 got = dut_outs();
    check("arst_outs", 32'({got.shift, got.load, got.serial, got.busy, got.done}), 32'd0);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    idle_steps(2);
    check("arst_no_load", 32'(loads.size()), 32'(nloads));
    stream = '0;
    step(1'b1, 16'h00FF, 1'b0);
    idle_steps(COLS + 2);
    check("arst_next_stream", 32'(stream), 32'h00FF);

    // COLS=2 build via vector table.
    foreach (v2[i]) begin
      got = mk(bus2.in_ready, bus2.shift_out, bus2.load_out, bus2.serial_out, bus2.busy, bus2.done);
      check($sformatf("cols2_row%0d", i), 32'(got), 32'(v2[i].exp));
      bus2.in_valid = v2[i].v;
      bus2.in_data  = v2[i].v ? v2[i].d : 2'bxx;
      @(negedge clk);
    end

    // Random traffic: valid toggling during SHIFT, changing data, rare aborts.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) < 6, COLS'($urandom), $urandom_range(0, 39) == 0);
    end
    idle_steps(COLS + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
